// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between CPU and loader ports; `ARB_FAIRNESS_EN enables burst-limited handover
module ram_port_arbiter #(
   parameter int ADDRESS_SIZE = 11,
   parameter int WORD_SIZE    = 64,
   parameter int MAX_BURST    = 4
) (
   input  logic                    clk,
   input  logic                    rstN,
   input  logic                    cpuReq,
   input  logic                    cpuWrite,
   input  logic [ADDRESS_SIZE-1:0] cpuAddress,
   input  logic [WORD_SIZE-1:0]    cpuDataIn,
   output logic                    cpuGnt,
   output logic                    cpuValid,
   output logic [WORD_SIZE-1:0]    cpuDataOut,
   input  logic                    ldReq,
   input  logic                    ldWrite,
   input  logic [ADDRESS_SIZE-1:0] ldAddress,
   input  logic [WORD_SIZE-1:0]    ldDataIn,
   output logic                    ldGnt,
   output logic                    ldValid,
   output logic [WORD_SIZE-1:0]    ldDataOut,
   output logic [ADDRESS_SIZE-1:0] ramAddress,
   output logic                    ramIsReading,
   output logic [WORD_SIZE-1:0]    ramDataIn,
   input  logic [WORD_SIZE-1:0]    ramDataOut
);
   typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_LD} state_t;
   state_t state_q, state_d;
   logic cpu_valid_q, ld_valid_q, fair_switch;
   logic [WORD_SIZE-1:0] cpu_data_q, ld_data_q;
   assign cpuGnt       = (state_q == OWN_CPU) & cpuReq;
   assign ldGnt        = (state_q == OWN_LD) & ldReq;
   assign ramAddress   = cpuGnt ? cpuAddress : ldGnt ? ldAddress : '0;
   assign ramDataIn    = cpuGnt ? cpuDataIn : ldGnt ? ldDataIn : '0;
   assign ramIsReading = cpuGnt ? ~cpuWrite : ldGnt ? ~ldWrite : 1'b1;
   assign cpuValid     = cpu_valid_q;
   assign ldValid      = ld_valid_q;
   assign cpuDataOut   = cpu_data_q;
   assign ldDataOut    = ld_data_q;
`ifdef ARB_FAIRNESS_EN
   localparam int BW = $clog2(MAX_BURST + 1);
   logic [BW-1:0] burst_q, burst_d;
   // force a handover when the owner is on its last allowed transaction and the other side waits
   assign fair_switch = (burst_q == BW'(MAX_BURST - 1)) & (cpuGnt ? ldReq : ldGnt ? cpuReq : 1'b0);
   // burst counter: counts owner transactions, restarts on every ownership change, saturates
   always_comb begin
      burst_d = (state_d != state_q) ? '0 :
                ((cpuGnt | ldGnt) && burst_q != BW'(MAX_BURST)) ? burst_q + 1'b1 : burst_q;
   end
   // burst counter register
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) burst_q <= '0;
      else       burst_q <= burst_d;
   end
`else
   assign fair_switch = 1'b0;
`endif
   // next-state: CPU wins from IDLE; owner keeps RAM until its req drops or fairness hands over
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = cpuReq ? OWN_CPU : ldReq ? OWN_LD : IDLE;
         OWN_CPU: state_d = (!cpuReq || fair_switch) ? (ldReq ? OWN_LD : IDLE) : OWN_CPU;
         OWN_LD:  state_d = (!ldReq || fair_switch) ? (cpuReq ? OWN_CPU : IDLE) : OWN_LD;
         default: state_d = IDLE;
      endcase
   end
   // ownership state register
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) state_q <= IDLE;
      else       state_q <= state_d;
   end
   // capture read data at the end of the grant cycle; valid pulses the following cycle
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         cpu_valid_q <= 1'b0;
         ld_valid_q  <= 1'b0;
         cpu_data_q  <= '0;
         ld_data_q   <= '0;
      end else begin
         cpu_valid_q <= cpuGnt & ~cpuWrite;
         ld_valid_q  <= ldGnt & ~ldWrite;
         if (cpuGnt && !cpuWrite) cpu_data_q <= ramDataOut;
         if (ldGnt && !ldWrite)   ld_data_q  <= ramDataOut;
      end
   end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed checks of grant, read/write routing, priority, fairness and withdrawal
module tb_ram_port_arbiter;
   logic        clk = 1'b0, rstN = 1'b0;
   logic        cpuReq = 1'b0, cpuWrite = 1'b0, ldReq = 1'b0, ldWrite = 1'b0;
   logic [10:0] cpuAddress = '0, ldAddress = '0, ramAddress;
   logic [63:0] cpuDataIn = '0, ldDataIn = '0, cpuDataOut, ldDataOut, ramDataIn, ramDataOut;
   logic        cpuGnt, cpuValid, ldGnt, ldValid, ramIsReading;
   logic [63:0] mem [0:2047];
   int n_cmp = 0, n_fail = 0;
`ifdef ARB_FAIRNESS_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   always #5 clk = ~clk;

   ram_port_arbiter #(.ADDRESS_SIZE(11), .WORD_SIZE(64), .MAX_BURST(4)) dut (
      .clk(clk), .rstN(rstN),
      .cpuReq(cpuReq), .cpuWrite(cpuWrite), .cpuAddress(cpuAddress), .cpuDataIn(cpuDataIn),
      .cpuGnt(cpuGnt), .cpuValid(cpuValid), .cpuDataOut(cpuDataOut),
      .ldReq(ldReq), .ldWrite(ldWrite), .ldAddress(ldAddress), .ldDataIn(ldDataIn),
      .ldGnt(ldGnt), .ldValid(ldValid), .ldDataOut(ldDataOut),
      .ramAddress(ramAddress), .ramIsReading(ramIsReading), .ramDataIn(ramDataIn), .ramDataOut(ramDataOut)
   );

   assign ramDataOut = mem[ramAddress];
   always @(posedge clk) begin
      if (!rstN) mem[16] <= 64'hDEADBEEF;
      else if (!ramIsReading) mem[ramAddress] <= ramDataIn;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(); step();
      n_cmp++; if (cpuGnt !== 1'b0 || ldGnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt cpu=%b ld=%b want 0 0", cpuGnt, ldGnt); end
      n_cmp++; if (cpuValid !== 1'b0 || ldValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid cpu=%b ld=%b want 0 0", cpuValid, ldValid); end
      n_cmp++; if (cpuDataOut !== 64'h0 || ldDataOut !== 64'h0) begin n_fail++; $display("FAIL reset_data cpu=%h ld=%h want 0", cpuDataOut, ldDataOut); end
      rstN = 1'b1;
      cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddress = 11'h010;
      step();
      n_cmp++; if (cpuGnt !== 1'b1) begin n_fail++; $display("FAIL pre_reset_gnt got=%b want 1", cpuGnt); end
      rstN = 1'b0;
      #1;
      n_cmp++; if (cpuGnt !== 1'b0 || ldGnt !== 1'b0 || ramIsReading !== 1'b1 || ramAddress !== 11'h0)
         begin n_fail++; $display("FAIL midread_reset gnt=%b%b rd=%b addr=%h want 00 1 000", cpuGnt, ldGnt, ramIsReading, ramAddress); end
      step();
      n_cmp++; if (cpuValid !== 1'b0 || ldValid !== 1'b0 || cpuDataOut !== 64'h0)
         begin n_fail++; $display("FAIL midread_valid valid=%b%b data=%h want 00 0", cpuValid, ldValid, cpuDataOut); end
      cpuReq = 1'b0; rstN = 1'b1;
      step();
   endtask

   task automatic test_cpu_read();
      cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddress = 11'h010;
      #1;
      n_cmp++; if (cpuGnt !== 1'b0 || ramIsReading !== 1'b1 || ramAddress !== 11'h0)
         begin n_fail++; $display("FAIL idle_outputs gnt=%b rd=%b addr=%h want 0 1 000", cpuGnt, ramIsReading, ramAddress); end
      step();
      n_cmp++; if (cpuGnt !== 1'b1 || ramAddress !== 11'h010 || ramIsReading !== 1'b1)
         begin n_fail++; $display("FAIL cpu_grant gnt=%b addr=%h rd=%b want 1 010 1", cpuGnt, ramAddress, ramIsReading); end
      step();
      cpuReq = 1'b0;
      #1;
      n_cmp++; if (cpuValid !== 1'b1 || cpuDataOut !== 64'hDEADBEEF)
         begin n_fail++; $display("FAIL cpu_read_data valid=%b data=%h want 1 deadbeef", cpuValid, cpuDataOut); end
      step();
      n_cmp++; if (cpuValid !== 1'b0 || cpuDataOut !== 64'hDEADBEEF)
         begin n_fail++; $display("FAIL cpu_valid_pulse valid=%b data=%h want 0 deadbeef", cpuValid, cpuDataOut); end
   endtask

   task automatic test_ld_write_cpu_read();
      ldReq = 1'b1; ldWrite = 1'b1; ldAddress = 11'h7FF; ldDataIn = 64'h1234;
      step();
      n_cmp++; if (ldGnt !== 1'b1 || ramIsReading !== 1'b0 || ramAddress !== 11'h7FF || ramDataIn !== 64'h1234)
         begin n_fail++; $display("FAIL ld_write gnt=%b rd=%b addr=%h din=%h want 1 0 7ff 1234", ldGnt, ramIsReading, ramAddress, ramDataIn); end
      step();
      ldReq = 1'b0; ldWrite = 1'b0;
      cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddress = 11'h7FF;
      #1;
      n_cmp++; if (ldValid !== 1'b0 || ramIsReading !== 1'b1)
         begin n_fail++; $display("FAIL ld_write_novalid valid=%b rd=%b want 0 1", ldValid, ramIsReading); end
      step();
      n_cmp++; if (cpuGnt !== 1'b1 || ramAddress !== 11'h7FF)
         begin n_fail++; $display("FAIL handover_cpu gnt=%b addr=%h want 1 7ff", cpuGnt, ramAddress); end
      step();
      cpuReq = 1'b0;
      #1;
      n_cmp++; if (cpuValid !== 1'b1 || cpuDataOut !== 64'h1234 || ldDataOut !== 64'h0)
         begin n_fail++; $display("FAIL cpu_read_back valid=%b data=%h ld=%h want 1 1234 0", cpuValid, cpuDataOut, ldDataOut); end
      step();
   endtask

   task automatic test_priority();
      cpuReq = 1'b1; cpuAddress = 11'h010; ldReq = 1'b1; ldWrite = 1'b0; ldAddress = 11'h7FF;
      step();
      n_cmp++; if (cpuGnt !== 1'b1 || ldGnt !== 1'b0)
         begin n_fail++; $display("FAIL cpu_priority cpu=%b ld=%b want 1 0", cpuGnt, ldGnt); end
      step();
      cpuReq = 1'b0;
      #1;
      n_cmp++; if (cpuGnt !== 1'b0 || ldGnt !== 1'b0 || ramIsReading !== 1'b1 || ramAddress !== 11'h0)
         begin n_fail++; $display("FAIL drop_cycle gnt=%b%b rd=%b addr=%h want 00 1 000", cpuGnt, ldGnt, ramIsReading, ramAddress); end
      step();
      n_cmp++; if (ldGnt !== 1'b1 || ramAddress !== 11'h7FF)
         begin n_fail++; $display("FAIL ld_next_cycle gnt=%b addr=%h want 1 7ff", ldGnt, ramAddress); end
      step();
      ldReq = 1'b0;
      #1;
      n_cmp++; if (ldValid !== 1'b1 || ldDataOut !== 64'h1234)
         begin n_fail++; $display("FAIL ld_read valid=%b data=%h want 1 1234", ldValid, ldDataOut); end
      step();
   endtask

   task automatic test_burst();
      logic exp_c;
      cpuReq = 1'b1; cpuAddress = 11'h010; ldReq = 1'b1; ldAddress = 11'h7FF;
      for (int i = 1; i <= 6; i++) begin
         step();
         exp_c = !FAIR || i <= 4;
         n_cmp++; if (cpuGnt !== exp_c || ldGnt !== !exp_c)
            begin n_fail++; $display("FAIL burst_cycle%0d cpu=%b ld=%b want %b %b", i, cpuGnt, ldGnt, exp_c, !exp_c); end
      end
      cpuReq = 1'b0;
      step();
      n_cmp++; if (ldGnt !== 1'b1 || cpuGnt !== 1'b0)
         begin n_fail++; $display("FAIL burst_release ld=%b cpu=%b want 1 0", ldGnt, cpuGnt); end
      ldReq = 1'b0;
      step();
      ldReq = 1'b1;
      #1;
      n_cmp++; if (ldGnt !== 1'b0)
         begin n_fail++; $display("FAIL burst_idle ld=%b want 0", ldGnt); end
      ldReq = 1'b0;
      step();
   endtask

   task automatic test_withdraw();
      cpuReq = 1'b1; cpuAddress = 11'h010; ldReq = 1'b1;
      step();
      ldReq = 1'b0;
      #1;
      n_cmp++; if (cpuGnt !== 1'b1 || ldGnt !== 1'b0)
         begin n_fail++; $display("FAIL withdraw_own cpu=%b ld=%b want 1 0", cpuGnt, ldGnt); end
      step();
      cpuReq = 1'b0;
      #1;
      n_cmp++; if (ldGnt !== 1'b0 || cpuGnt !== 1'b0)
         begin n_fail++; $display("FAIL withdraw_drop cpu=%b ld=%b want 0 0", cpuGnt, ldGnt); end
      step();
      ldReq = 1'b1;
      #1;
      n_cmp++; if (ldGnt !== 1'b0 || ramIsReading !== 1'b1)
         begin n_fail++; $display("FAIL withdraw_idle ld=%b rd=%b want 0 1", ldGnt, ramIsReading); end
      step();
      n_cmp++; if (ldGnt !== 1'b1)
         begin n_fail++; $display("FAIL withdraw_later_ld ld=%b want 1", ldGnt); end
      ldReq = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_cpu_read();
      test_ld_write_cpu_read();
      test_priority();
      test_burst();
      test_withdraw();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
